// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback path.
// Holds data/index widths, register count and the writeback source enum.
package regfile_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/regfile_writeback_ctrl_rr_arbiter2.sv
// Two-requester round-robin arbiter; gnt[0]=ALU, gnt[1]=LSU, one-hot.
// Ports: clk, reset (async low), en, req[1:0] in; gnt[1:0] out.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  wb_src_e last_grant;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (1'b1)
        (req == 2'b11):
          gnt = (last_grant == WB_ALU) ? 2'b10 : 2'b01;
        (req == 2'b01): gnt = 2'b01;
        (req == 2'b10): gnt = 2'b10;
        default:        gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= WB_ALU;
    end else if (gnt[0]) begin
      last_grant <= WB_ALU;
    end else if (gnt[1]) begin
      last_grant <= WB_LSU;
    end
  end

endmodule

// File: rtl/regfile_writeback_ctrl.sv
// Register-file write side: ALU/LSU result arbitration, one-stage write
// register, per-register busy scoreboard and sticky writeback error flag.
// Ports: clk, reset, flush; alloc_*; alu_*; lsu_*; wb_*; q_rs1/2, rs1/2_busy.
module regfile_writeback_ctrl
  import regfile_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            alloc_valid,
  input  logic [AW-1:0]   alloc_rd,
  output logic            alloc_ready,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  output logic            wb_en,
  output logic [AW-1:0]   wb_rd,
  output logic [XLEN-1:0] wb_data,
  input  logic [AW-1:0]   q_rs1,
  input  logic [AW-1:0]   q_rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            wb_err
);

  // Bit 0 is never set, so x0 always reads as idle.
  logic [NREG-1:0] busy;
  logic [1:0]      gnt;
  logic            accept;
  logic            alloc_fire;
  logic [AW-1:0]   res_rd;
  logic [XLEN-1:0] res_data;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (~flush),
    .req   ({lsu_valid, alu_valid}),
    .gnt   (gnt)
  );

  assign alu_ready = gnt[0];
  assign lsu_ready = gnt[1];
  assign accept    = |gnt;
  assign res_rd    = gnt[1] ? lsu_rd : alu_rd;
  assign res_data  = gnt[1] ? lsu_data : alu_data;

  assign alloc_ready = ~flush &
                       ((alloc_rd == '0) | ~busy[alloc_rd]);
  assign alloc_fire  = alloc_valid & alloc_ready;

  assign rs1_busy = busy[q_rs1] & (q_rs1 != '0);
  assign rs2_busy = busy[q_rs2] & (q_rs2 != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      if (wb_en) busy[wb_rd] <= 1'b0;
      if (alloc_fire && alloc_rd != '0)
        busy[alloc_rd] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_en   <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else if (flush) begin
      wb_en <= 1'b0;
    end else begin
      wb_en <= accept & (res_rd != '0);
      if (accept) begin
        wb_rd   <= res_rd;
        wb_data <= res_data;
      end
    end
  end

  // A result for a register nobody allocated is still written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_err <= 1'b0;
    end else if (accept && res_rd != '0 && !busy[res_rd]) begin
      wb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Directed self-checking bench for regfile_writeback_ctrl.
// One task per scenario; inputs change 1ns after posedge, checks follow.
module tb_regfile_writeback_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        alloc_valid;
  logic [4:0]  alloc_rd;
  logic        alloc_ready;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  q_rs1;
  logic [4:0]  q_rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        wb_err;

  int errors = 0;
  int checks = 0;

  regfile_writeback_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .alloc_valid (alloc_valid),
    .alloc_rd    (alloc_rd),
    .alloc_ready (alloc_ready),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .lsu_valid   (lsu_valid),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .lsu_ready   (lsu_ready),
    .wb_en       (wb_en),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .q_rs1       (q_rs1),
    .q_rs2       (q_rs2),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .wb_err      (wb_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0;
    alloc_valid = 1'b0; alloc_rd = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    q_rs1 = 5'd5; q_rs2 = 5'd9;
    tick(); tick();
    checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL reset_wb_en got %b want 0", wb_en); end
    checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL reset_wb_rd got %0d want 0", wb_rd); end
    checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL reset_wb_data got %h want 0", wb_data); end
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL reset_wb_err got %b want 0", wb_err); end
    checks++; if ({rs1_busy, rs2_busy} !== 2'b00) begin errors++; $display("FAIL reset_busy got %b want 00", {rs1_busy, rs2_busy}); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    alloc_valid = 1'b1; alloc_rd = 5'd5; q_rs1 = 5'd5;
    #1;
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL t1_alloc_ready got %b want 1", alloc_ready); end
    tick();
    alloc_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL t1_busy_set got %b want 1", rs1_busy); end
    checks++; if ({alu_ready, lsu_ready} !== 2'b10) begin errors++; $display("FAIL t1_ready got %b want 10", {alu_ready, lsu_ready}); end
    tick();
    alu_valid = 1'b0;
    #1;
    checks++; if ({wb_en, wb_rd, wb_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin errors++; $display("FAIL t1_wb got en=%b rd=%0d data=%h want en=1 rd=5 data=deadbeef", wb_en, wb_rd, wb_data); end
    checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL t1_busy_during_wb got %b want 1", rs1_busy); end
    tick();
    checks++; if ({wb_en, rs1_busy, wb_err} !== 3'b000) begin errors++; $display("FAIL t1_after got en,busy,err=%b want 000", {wb_en, rs1_busy, wb_err}); end
  endtask

  task automatic test_round_robin();
    alloc_valid = 1'b1; alloc_rd = 5'd3;
    tick();
    alloc_rd = 5'd4;
    tick();
    alloc_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h3333_0003;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h4444_0004;
    #1;
    checks++; if ({alu_ready, lsu_ready} !== 2'b01) begin errors++; $display("FAIL t2_first_grant got %b want 01", {alu_ready, lsu_ready}); end
    tick();
    lsu_valid = 1'b0;
    #1;
    checks++; if ({alu_ready, lsu_ready} !== 2'b10) begin errors++; $display("FAIL t2_second_grant got %b want 10", {alu_ready, lsu_ready}); end
    checks++; if ({wb_en, wb_rd, wb_data} !== {1'b1, 5'd4, 32'h4444_0004}) begin errors++; $display("FAIL t2_wb_first got en=%b rd=%0d data=%h want 1/4/44440004", wb_en, wb_rd, wb_data); end
    tick();
    alu_valid = 1'b0;
    #1;
    checks++; if ({wb_en, wb_rd, wb_data} !== {1'b1, 5'd3, 32'h3333_0003}) begin errors++; $display("FAIL t2_wb_second got en=%b rd=%0d data=%h want 1/3/33330003", wb_en, wb_rd, wb_data); end
    tick();
    q_rs1 = 5'd3; q_rs2 = 5'd4;
    #1;
    checks++; if ({wb_en, rs1_busy, rs2_busy} !== 3'b000) begin errors++; $display("FAIL t2_idle got en,b1,b2=%b want 000", {wb_en, rs1_busy, rs2_busy}); end
  endtask

  task automatic test_waw_stall();
    alloc_valid = 1'b1; alloc_rd = 5'd7;
    #1;
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL t3_first_alloc got %b want 1", alloc_ready); end
    tick();
    checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL t3_stall1 got %b want 0", alloc_ready); end
    tick();
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h0000_0777;
    #1;
    checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL t3_stall2 got %b want 0", alloc_ready); end
    tick();
    alu_valid = 1'b0;
    #1;
    checks++; if ({wb_en, wb_rd, alloc_ready} !== {1'b1, 5'd7, 1'b0}) begin errors++; $display("FAIL t3_wb_cycle got en=%b rd=%0d rdy=%b want 1/7/0", wb_en, wb_rd, alloc_ready); end
    tick();
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL t3_released got %b want 1", alloc_ready); end
    alloc_valid = 1'b0;
    tick();
  endtask

  task automatic test_x0();
    alloc_valid = 1'b1; alloc_rd = 5'd0; q_rs1 = 5'd0;
    #1;
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL t4_alloc_x0 got %b want 1", alloc_ready); end
    tick();
    alloc_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0000_1234;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL t4_accept got %b want 1", alu_ready); end
    tick();
    alu_valid = 1'b0;
    #1;
    checks++; if ({wb_en, wb_err, rs1_busy} !== 3'b000) begin errors++; $display("FAIL t4_no_write got en,err,busy=%b want 000", {wb_en, wb_err, rs1_busy}); end
    tick();
  endtask

  task automatic test_unallocated();
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0000_0999;
    tick();
    alu_valid = 1'b0;
    #1;
    checks++; if ({wb_en, wb_rd, wb_err} !== {1'b1, 5'd9, 1'b1}) begin errors++; $display("FAIL t5_write got en=%b rd=%0d err=%b want 1/9/1", wb_en, wb_rd, wb_err); end
    tick(); tick(); tick();
    checks++; if ({wb_en, wb_err} !== 2'b01) begin errors++; $display("FAIL t5_sticky got en,err=%b want 01", {wb_en, wb_err}); end
  endtask

  task automatic test_flush();
    alloc_valid = 1'b1; alloc_rd = 5'd2;
    tick();
    alloc_rd = 5'd6;
    tick();
    alloc_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h0000_0222;
    tick();
    alu_valid = 1'b0;
    flush = 1'b1;
    lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 32'h0000_0666;
    alloc_valid = 1'b1; alloc_rd = 5'd11;
    q_rs1 = 5'd2; q_rs2 = 5'd6;
    #1;
    checks++; if ({alu_ready, lsu_ready, alloc_ready} !== 3'b000) begin errors++; $display("FAIL t6_flush_ready got %b want 000", {alu_ready, lsu_ready, alloc_ready}); end
    checks++; if ({rs1_busy, rs2_busy} !== 2'b11) begin errors++; $display("FAIL t6_busy_before got %b want 11", {rs1_busy, rs2_busy}); end
    tick();
    flush = 1'b0;
    lsu_valid = 1'b0;
    alloc_valid = 1'b0;
    q_rs2 = 5'd11;
    #1;
    checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL t6_wb_dropped got %b want 0", wb_en); end
    checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL t6_busy2 got %b want 0", rs1_busy); end
    q_rs2 = 5'd6;
    #1;
    checks++; if (rs2_busy !== 1'b0) begin errors++; $display("FAIL t6_busy6 got %b want 0", rs2_busy); end
    q_rs2 = 5'd11;
    #1;
    checks++; if (rs2_busy !== 1'b0) begin errors++; $display("FAIL t6_no_alloc_in_flush got %b want 0", rs2_busy); end
  endtask

  task automatic test_async_reset();
    alloc_valid = 1'b1; alloc_rd = 5'd12; q_rs1 = 5'd12;
    tick();
    alloc_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checks++; if ({wb_err, rs1_busy} !== 2'b00) begin errors++; $display("FAIL t7_async_reset got err,busy=%b want 00", {wb_err, rs1_busy}); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_waw_stall();
    test_x0();
    test_unallocated();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
